riscv_mem_arbiter: RTL and testbench

Shares one single-port synchronous memory between the hart's instruction-fetch port and its load/store port, so a single unified RAM holds both program and data. Each cycle it grants at most one requester, drives the memory port, and routes the one-cycle-latency read data back to the owner of the access. Data accesses have priority; an optional starvation guard keeps fetch from stalling indefinitely.

---
 rtl/riscv_mem_arb_pkg.sv | 12 +
 rtl/riscv_mem_arbiter_if.sv | 37 +++
 rtl/riscv_arb_streak_counter.sv | 24 ++
 rtl/riscv_mem_arbiter.sv | 56 +++++
 tb/tb_riscv_mem_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_arb_pkg.sv
// riscv_mem_arb_pkg: shared response-owner type and default starvation limit for the memory arbiter.
package riscv_mem_arb_pkg;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_IF,
        RESP_D
    } resp_owner_e;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if: fetch, load/store and memory-side signals of the arbiter.
interface riscv_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/riscv_arb_streak_counter.sv
// riscv_arb_streak_counter: saturating up-counter with synchronous clear; sat flags the limit.
module riscv_arb_streak_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic sat
);

    localparam int W = $clog2(LIMIT + 2);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : (inc && cnt_q != W'(LIMIT)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;

    assign sat = cnt_q == W'(LIMIT);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: one single-port RAM shared by fetch and load/store, data port first.
// Define RISCV_MEM_ARB_STARVE_EN to force a fetch grant after STARVE_LIMIT waiting data grants.
module riscv_mem_arbiter
    import riscv_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic clk,
    input logic rst,
    riscv_mem_arbiter_if.slave bus
);

    resp_owner_e resp_q, resp_d;
    logic        starve;
    logic        if_gnt;
    logic        d_gnt;

`ifdef RISCV_MEM_ARB_STARVE_EN
    riscv_arb_streak_counter #(.LIMIT(STARVE_LIMIT)) u_streak (
        .clk (clk),
        .rst (rst),
        .clr (if_gnt | ~bus.if_req),
        .inc (d_gnt & bus.if_req),
        .sat (starve)
    );
`else
    assign starve = STARVE_LIMIT < 0;
`endif

    // Grants stay low while rst is held, even with requests pending.
    always_comb begin
        if_gnt = ~rst & bus.if_req & (~bus.d_req | starve);
        d_gnt  = ~rst & bus.d_req & ~if_gnt;
        resp_d = if_gnt ? RESP_IF : (d_gnt & ~bus.d_we) ? RESP_D : RESP_NONE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) resp_q <= RESP_NONE;
        else resp_q <= resp_d;

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = if_gnt | d_gnt;
    assign bus.mem_we    = d_gnt & bus.d_we;
    assign bus.mem_addr  = d_gnt ? {bus.d_addr[ADDR_WIDTH-1:2], 2'b00} :
                           if_gnt ? {bus.if_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus.mem_wdata = d_gnt ? bus.d_wdata : '0;

    assign bus.if_rvalid = resp_q == RESP_IF;
    assign bus.d_rvalid  = resp_q == RESP_D;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
    assign bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: random and directed traffic against a reference memory and arbitration model.
module tb_riscv_mem_arbiter;
    import riscv_mem_arb_pkg::*;

    localparam int LIMIT = 4;
`ifdef RISCV_MEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    typedef struct {
        int          due;
        resp_owner_e own;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_init = 1'b1;
    int          cyc = 0;
    int          pass = 0;
    int          total = 0;
    int          if_wait = 0;
    bit          gi, gd;
    exp_t        exp_q[$];
    logic [31:0] ram [64];
    logic [31:0] ref_mem [64];
    resp_owner_e m_own;
    logic [31:0] m_dat;

    riscv_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    riscv_mem_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(int i);
        return i == 1 ? 32'hDEADBEEF : 32'hA500_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // The physical single-port RAM: one-cycle read latency, write at the edge.
    always @(posedge clk)
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
            else bus.mem_rdata <= ram[bus.mem_addr[7:2]];
        end

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    endtask

    task automatic expect_resp(resp_owner_e o, logic [31:0] d);
        exp_t e;
        e.due = cyc + 1;
        e.own = o;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle, pop the response due now (if any) and compare both read ports.
    always @(negedge clk) begin
        m_own = RESP_NONE;
        m_dat = 32'h0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            m_own = exp_q[0].own;
            m_dat = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        check("if_resp", {31'b0, bus.if_rvalid, bus.if_rdata},
              {31'b0, m_own == RESP_IF, m_own == RESP_IF ? m_dat : 32'h0});
        check("d_resp", {31'b0, bus.d_rvalid, bus.d_rdata},
              {31'b0, m_own == RESP_D, m_own == RESP_D ? m_dat : 32'h0});
    end

    // Reference model: data first, fetch forced once it has waited LIMIT cycles (guard builds).
    task automatic step();
        logic        ed, ei;
        logic [31:0] ea;
        ed = !rst && bus.d_req && !(STARVE && bus.if_req && if_wait >= LIMIT);
        ei = !rst && bus.if_req && !ed;
        ea = ed ? bus.d_addr : ei ? bus.if_addr : 32'h0;
        check("grant", {62'b0, bus.if_gnt, bus.d_gnt}, {62'b0, ei, ed});
        check("mem_ctl", {62'b0, bus.mem_en, bus.mem_we}, {62'b0, ed || ei, ed && bus.d_we});
        check("mem_addr", {32'b0, bus.mem_addr}, {32'b0, ea & ~32'h3});
        if (!ei) check("mem_wdata", {32'b0, bus.mem_wdata}, {32'b0, ed ? bus.d_wdata : 32'h0});
        if (ed && bus.d_we) ref_mem[bus.d_addr[7:2]] = bus.d_wdata;
        else if (ed) expect_resp(RESP_D, ref_mem[bus.d_addr[7:2]]);
        if (ei) expect_resp(RESP_IF, ref_mem[bus.if_addr[7:2]]);
        if_wait = (!rst && bus.if_req && !ei) ? if_wait + 1 : 0;
        gi = ei;
        gd = ed;
    endtask

    task automatic tick();
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_drop();
        tick();
        if (gi) bus.if_req = 1'b0;
        if (gd) bus.d_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((bus.if_req || bus.d_req) && n < 20) begin
            tick_drop();
            n++;
        end
        check("drain_bound", {63'b0, n < 20}, 64'd1);
        tick_drop();
    endtask

    task automatic set_d(logic we, logic [31:0] addr, logic [31:0] wd);
        bus.d_req = 1'b1;
        bus.d_we = we;
        bus.d_addr = addr;
        bus.d_wdata = wd;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h20;
        set_d(1'b0, 32'h13, 32'h0);
        tick();
        tick();
        ram_init = 1'b0;
        rst = 1'b0;
        drain();

        bus.if_req = 1'b1;
        bus.if_addr = 32'h4;
        drain();

        set_d(1'b1, 32'hC, 32'd42);
        tick_drop();
        set_d(1'b0, 32'hC, 32'h0);
        drain();

        bus.if_req = 1'b1;
        bus.if_addr = 32'h10;
        set_d(1'b0, 32'h8, 32'h0);
        drain();

        bus.if_req = 1'b1;
        bus.if_addr = 32'h40;
        set_d(1'b0, 32'h80, 32'h0);
        repeat (16) begin
            tick();
            if (gi) bus.if_addr = bus.if_addr + 32'h4;
            if (gd) set_d(~bus.d_we, bus.d_addr + 32'h4, $urandom);
        end

        repeat (400) begin
            tick();
            if (gi || !bus.if_req) begin
                bus.if_req = $urandom_range(0, 3) != 0;
                bus.if_addr = $urandom_range(0, 255);
            end
            if (gd || !bus.d_req) begin
                set_d($urandom_range(0, 1) == 1, $urandom_range(0, 255), $urandom);
                bus.d_req = $urandom_range(0, 2) != 0;
            end
        end
        drain();

        // A fetch granted just before reset must never produce rvalid.
        bus.if_req = 1'b1;
        bus.if_addr = 32'h24;
        tick_drop();
        rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
